// File: rtl/snn_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous memory between two requesters.
// Define SNN_MEM_CLEAR_EN to zero-fill the memory after reset before any request is accepted.
module snn_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DW-1:0]     req0_wdata,
  output logic              rsp0_valid,
  output logic [DW-1:0]     rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DW-1:0]     req1_wdata,
  output logic              rsp1_valid,
  output logic [DW-1:0]     rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              init_done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              run;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     wdata_q;
`ifdef SNN_MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  assign run = rst_n && (state == ST_RUN);

  always_comb begin
    grant0 = run && req0_valid && (!req1_valid || !rr_ptr);
    grant1 = run && req1_valid && (!req0_valid || rr_ptr);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_done  = (state == ST_RUN);
  assign rsp0_rdata = mem_rdata;
  assign rsp1_rdata = mem_rdata;

  // Idle cycles replay the registered copy so the memory bus never floats.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (grant0) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (grant1) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
`ifdef SNN_MEM_CLEAR_EN
    else if (state == ST_CLEAR) begin
      mem_we    = rst_n;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    addr_q  <= mem_addr;
    wdata_q <= mem_wdata;
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef SNN_MEM_CLEAR_EN
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
`else
      state      <= ST_RUN;
`endif
    end else begin
      rsp0_valid <= grant0 && !req0_we;
      rsp1_valid <= grant1 && !req1_we;
      if (grant0) begin
        rr_ptr <= 1'b1;
      end else if (grant1) begin
        rr_ptr <= 1'b0;
      end
`ifdef SNN_MEM_CLEAR_EN
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) begin
          state <= ST_RUN;
        end
      end
`endif
    end
  end

endmodule
